// File: rtl/m_inst_sched.sv
// In-order matrix instruction scheduler: buffers controller instructions, dispatches RUNs to
// NumCh channels with per-channel outstanding limits, and executes BARRIER/WSYNC/RSYNC.
module m_inst_sched #(
    parameter int InstW  = 64,
    parameter int NumCh  = 2,
    parameter int QDepth = 4,
    parameter int MaxOut = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       mValid,
    output logic                       mReady,
    input  logic [InstW-1:0]           mInst,
    output logic [NumCh-1:0]           chValid,
    input  logic [NumCh-1:0]           chReady,
    output logic [NumCh*InstW-1:0]     chInst,
    input  logic [NumCh-1:0]           chDone,
    input  logic                       amEmpty,
    output logic                       mvWSync,
    output logic                       amRSync,
    output logic [$clog2(QDepth):0]    qCount,
    output logic                       busy,
    output logic                       err
);

    localparam int ChSelW = (NumCh > 1) ? $clog2(NumCh) : 1;
    localparam int PtrW   = $clog2(QDepth);

    localparam logic [1:0] OpRun     = 2'b00;
    localparam logic [1:0] OpBarrier = 2'b01;
    localparam logic [1:0] OpWSync   = 2'b10;
    localparam logic [1:0] OpRSync   = 2'b11;

    logic [InstW-1:0] mem_q [QDepth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PtrW:0]    count_q, count_d;
    logic             rst_done_q;
    logic [3:0]       out_cnt_q [NumCh];
    logic [3:0]       out_cnt_d [NumCh];
    logic             err_q, err_d;
    logic             wsync_q, wsync_d;
    logic             rsync_q, rsync_d;

    logic             head_valid;
    logic [InstW-1:0] head;
    logic [1:0]       head_op;
    logic [3:0]       head_ch;
    logic             ch_bad;
    logic             full;
    logic             all_idle;
    logic             push;
    logic             pop;
    logic [NumCh-1:0] ch_valid;
    logic [NumCh-1:0] dispatch;

    assign head_valid = (count_q != '0);
    assign head       = mem_q[rd_ptr_q];
    assign head_op    = head[InstW-1 -: 2];
    // Widened so an out-of-range channel index is detectable for any NumCh.
    assign head_ch    = 4'(head[InstW-3 -: ChSelW]);
    assign ch_bad     = (head_ch >= 4'(NumCh));
    assign full       = (count_q == (PtrW+1)'(QDepth));

    always_comb begin
        all_idle = 1'b1;
        for (int c = 0; c < NumCh; c++) begin
            if (out_cnt_q[c] != 4'd0) all_idle = 1'b0;
        end
    end

    // Stall decision uses the registered count, so a same-cycle chDone unblocks one cycle later.
    always_comb begin
        ch_valid = '0;
        for (int c = 0; c < NumCh; c++) begin
            ch_valid[c] = head_valid && (head_op == OpRun) && (head_ch == 4'(c))
                          && (out_cnt_q[c] < 4'(MaxOut));
        end
        dispatch = ch_valid & chReady;
    end

    always_comb begin
        pop = 1'b0;
        if (head_valid) begin
            case (head_op)
                OpRun:             pop = ch_bad || (|dispatch);
                OpBarrier, OpWSync: pop = all_idle;
                OpRSync:           pop = !amEmpty;
                default:           pop = 1'b0;
            endcase
        end
    end

    // A full queue still accepts when the head leaves in the same cycle.
    assign mReady = rst_done_q && (!full || pop);
    assign push   = mValid && mReady;

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop)      count_d = count_q + (PtrW+1)'(1);
        else if (pop && !push) count_d = count_q - (PtrW+1)'(1);

        err_d = err_q || (pop && (head_op == OpRun) && ch_bad);
        for (int c = 0; c < NumCh; c++) begin
            out_cnt_d[c] = out_cnt_q[c];
            if (chDone[c] && (out_cnt_q[c] == 4'd0)) begin
                err_d = 1'b1;
                if (dispatch[c]) out_cnt_d[c] = out_cnt_q[c] + 4'd1;
            end else if (dispatch[c] && !chDone[c]) begin
                out_cnt_d[c] = out_cnt_q[c] + 4'd1;
            end else if (!dispatch[c] && chDone[c]) begin
                out_cnt_d[c] = out_cnt_q[c] - 4'd1;
            end
        end

        wsync_d = pop && (head_op == OpWSync);
        rsync_d = pop && (head_op == OpRSync);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rst_done_q <= 1'b0;
            err_q      <= 1'b0;
            wsync_q    <= 1'b0;
            rsync_q    <= 1'b0;
            for (int c = 0; c < NumCh; c++) out_cnt_q[c] <= 4'd0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rst_done_q <= 1'b1;
            err_q      <= err_d;
            wsync_q    <= wsync_d;
            rsync_q    <= rsync_d;
            for (int c = 0; c < NumCh; c++) out_cnt_q[c] <= out_cnt_d[c];
        end
    end

    // NOTE: the storage array has no reset; count_q alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= mInst;
    end

    always_comb begin
        chInst = '0;
        for (int c = 0; c < NumCh; c++) begin
            chInst[c*InstW +: InstW] = head_valid ? head : '0;
        end
    end

    assign chValid = ch_valid;
    assign mvWSync = wsync_q;
    assign amRSync = rsync_q;
    assign qCount  = count_q;
    assign busy    = head_valid || !all_idle;
    assign err     = err_q;

endmodule

// File: tb/tb_m_inst_sched.sv
// Self-checking bench for m_inst_sched: directed scenarios plus random traffic, all compared
// every cycle against a queue-based reference model of the scheduling rules.
module tb_m_inst_sched;

    localparam int InstW  = 64;
    localparam int NumCh  = 2;
    localparam int QDepth = 4;
    localparam int MaxOut = 3;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   mValid = 1'b0;
    logic                   mReady;
    logic [InstW-1:0]       mInst = '0;
    logic [NumCh-1:0]       chValid;
    logic [NumCh-1:0]       chReady = '0;
    logic [NumCh*InstW-1:0] chInst;
    logic [NumCh-1:0]       chDone = '0;
    logic                   amEmpty = 1'b1;
    logic                   mvWSync;
    logic                   amRSync;
    logic [2:0]             qCount;
    logic                   busy;
    logic                   err;

    always #5 clk = ~clk;

    m_inst_sched #(.InstW(InstW), .NumCh(NumCh), .QDepth(QDepth), .MaxOut(MaxOut)) dut (
        .clk(clk), .rst_n(rst_n), .mValid(mValid), .mReady(mReady), .mInst(mInst),
        .chValid(chValid), .chReady(chReady), .chInst(chInst), .chDone(chDone),
        .amEmpty(amEmpty), .mvWSync(mvWSync), .amRSync(amRSync), .qCount(qCount),
        .busy(busy), .err(err)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model state
    logic [63:0] mq[$];
    logic [63:0] src[$];
    int          mcnt[NumCh];
    bit          merr, mrst_done, mpw, mpr;
    bit          valid_en = 1'b1;

    function automatic logic [63:0] mk(input logic [1:0] op, input logic ch);
        logic [63:0] r;
        r = {$urandom, $urandom};
        r[63:62] = op;
        r[61] = ch;
        return r;
    endfunction

    // Drives mValid/mInst from src, compares at negedge, advances the model, returns at posedge+1.
    task automatic tick();
        logic [1:0]   op;
        int           sel;
        bit           pop, push, exp_ready, idle;
        logic [1:0]   exp_cv;
        logic [127:0] exp_inst;
        mValid = valid_en && (src.size() > 0);
        mInst  = (src.size() > 0) ? src[0] : '0;
        @(negedge clk);
        pop = 0; exp_cv = '0; op = 2'b00; sel = 0; exp_inst = '0;
        idle = 1;
        for (int c = 0; c < NumCh; c++) if (mcnt[c] != 0) idle = 0;
        if (mq.size() > 0) begin
            op  = mq[0][63:62];
            sel = int'(mq[0][61]);
            exp_inst = {mq[0], mq[0]};
            case (op)
                2'b00: begin
                    if (mcnt[sel] < MaxOut) exp_cv[sel] = 1'b1;
                    pop = exp_cv[sel] && chReady[sel];
                end
                2'b01, 2'b10: pop = idle;
                default:      pop = !amEmpty;
            endcase
        end
        exp_ready = mrst_done && (mq.size() < QDepth || pop);
        push = mValid && exp_ready;
        check("mReady", mReady, exp_ready);
        check("chValid", chValid, exp_cv);
        check("chInst", chInst, exp_inst);
        check("qCount", qCount, mq.size());
        check("mvWSync", mvWSync, mpw);
        check("amRSync", amRSync, mpr);
        check("busy", busy, (mq.size() > 0) || !idle);
        check("err", err, merr);
        for (int c = 0; c < NumCh; c++) begin
            bit inc;
            inc = pop && (op == 2'b00) && (sel == c);
            if (chDone[c] && mcnt[c] == 0) merr = 1;
            else if (chDone[c]) mcnt[c]--;
            if (inc) mcnt[c]++;
        end
        mpw = pop && (op == 2'b10);
        mpr = pop && (op == 2'b11);
        if (pop) void'(mq.pop_front());
        if (push) begin
            mq.push_back(mInst);
            void'(src.pop_front());
        end
        mrst_done = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        mValid = 1'b0; chReady = '0; chDone = '0; amEmpty = 1'b1;
        src.delete(); mq.delete();
        for (int c = 0; c < NumCh; c++) mcnt[c] = 0;
        merr = 0; mrst_done = 0; mpw = 0; mpr = 0;
        #2;
        check("rst_mReady", mReady, 0);
        check("rst_chValid", chValid, 0);
        check("rst_chInst", chInst, 0);
        check("rst_mvWSync", mvWSync, 0);
        check("rst_amRSync", amRSync, 0);
        check("rst_qCount", qCount, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic drain(input int bound);
        int n = 0;
        valid_en = 1'b1;
        while ((src.size() > 0 || mq.size() > 0 || mcnt[0] > 0 || mcnt[1] > 0) && n < bound) begin
            chReady = '1;
            amEmpty = 1'b0;
            for (int c = 0; c < NumCh; c++) chDone[c] = (mcnt[c] > 0) && ($urandom_range(0, 1) == 1);
            tick();
            n++;
        end
        chDone = '0;
        tick();
        check("drain_idle", busy, 0);
    endtask

    initial begin
        do_reset();
        for (int i = 0; i < 3; i++) tick();

        // Fill beyond depth with channel 1 blocked, then release and hit the outstanding limit.
        chReady = 2'b00;
        for (int i = 0; i < 5; i++) src.push_back(mk(2'b00, 1'b1));
        for (int i = 0; i < 6; i++) tick();
        check("full_qCount", qCount, 4);
        check("full_mReady", mReady, 0);
        chReady = 2'b10;
        tick();
        check("pushpop_full_qCount", qCount, 4);
        tick(); tick(); tick();
        check("stall_chValid", chValid, 2'b00);
        check("stall_qCount", qCount, 2);
        chDone = 2'b10;
        tick();
        chDone = 2'b00;
        check("unstall_chValid", chValid, 2'b10);
        drain(200);

        // WSYNC waits for both channels to go idle.
        chReady = 2'b11;
        src.push_back(mk(2'b00, 1'b0));
        src.push_back(mk(2'b00, 1'b1));
        src.push_back(mk(2'b10, 1'b0));
        for (int i = 0; i < 6; i++) tick();
        check("wsync_wait", mvWSync, 0);
        chDone = 2'b01; tick();
        chDone = 2'b00; tick(); tick();
        check("wsync_wait2", mvWSync, 0);
        chDone = 2'b10; tick();
        chDone = 2'b00; tick();
        check("wsync_pulse", mvWSync, 1);
        tick();
        check("wsync_end", mvWSync, 0);

        // RSYNC held while amEmpty is high, blocking the entry behind it.
        amEmpty = 1'b1;
        src.push_back(mk(2'b11, 1'b0));
        src.push_back(mk(2'b00, 1'b0));
        for (int i = 0; i < 12; i++) tick();
        check("rsync_hold", amRSync, 0);
        check("rsync_qCount", qCount, 2);
        amEmpty = 1'b0;
        tick();
        check("rsync_pulse", amRSync, 1);
        tick();
        check("rsync_end", amRSync, 0);
        drain(200);

        // Dispatch and chDone together on ch0, then a stray chDone on idle ch1.
        chReady = 2'b00;
        for (int i = 0; i < 3; i++) src.push_back(mk(2'b00, 1'b0));
        for (int i = 0; i < 4; i++) tick();
        chReady = 2'b01;
        tick(); tick();
        chDone = 2'b01; tick();
        chDone = 2'b10; tick();
        chDone = 2'b00;
        check("err_set", err, 1);
        for (int i = 0; i < 3; i++) tick();
        check("err_sticky", err, 1);
        drain(200);

        // Reset in the middle of traffic.
        chReady = 2'b00;
        for (int i = 0; i < 3; i++) src.push_back(mk(2'b00, 1'($urandom)));
        for (int i = 0; i < 3; i++) tick();
        do_reset();
        tick();

        for (int i = 0; i < 1500; i++) begin
            if (src.size() < 2 && $urandom_range(0, 1) == 1) begin
                int r;
                logic [1:0] op;
                r = $urandom_range(0, 9);
                op = (r < 7) ? 2'b00 : (r == 7) ? 2'b01 : (r == 8) ? 2'b10 : 2'b11;
                src.push_back(mk(op, 1'($urandom)));
            end
            valid_en = ($urandom_range(0, 3) != 0);
            chReady  = 2'($urandom);
            amEmpty  = 1'($urandom);
            for (int c = 0; c < NumCh; c++) chDone[c] = (mcnt[c] > 0) && ($urandom_range(0, 2) == 0);
            tick();
        end
        drain(400);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
